// File: rtl/brick_pkg.sv
// Shared brick-field geometry, scoring and FSM types for the brick manager.
package brick_pkg;

    localparam int unsigned BRICK_W    = 124;
    localparam int unsigned BRICK_H    = 20;
    localparam int unsigned PITCH_X    = 128;
    localparam int unsigned PITCH_Y    = 24;
    localparam int unsigned NUM_COLS   = 5;
    localparam int unsigned NUM_ROWS   = 3;
    localparam int unsigned NUM_BRICKS = 15;

    localparam logic [1:0] ROW0_POINTS = 2'd3;
    localparam logic [1:0] ROW1_POINTS = 2'd2;
    localparam logic [1:0] ROW2_POINTS = 2'd1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StResolve
    } state_e;

    function automatic logic [2:0] brick_col(input logic [3:0] idx);
        return 3'(idx % 4'(NUM_COLS));
    endfunction

    function automatic logic [1:0] brick_row(input logic [3:0] idx);
        return 2'(idx / 4'(NUM_COLS));
    endfunction

    function automatic logic [1:0] brick_points(input logic [1:0] row);
        case (row)
            2'd0:    return ROW0_POINTS;
            2'd1:    return ROW1_POINTS;
            default: return ROW2_POINTS;
        endcase
    endfunction

endpackage

// File: rtl/brick_overlap.sv
// Combinational ball-versus-brick test for a single brick index.
module brick_overlap
    import brick_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 8
) (
    input  logic [3:0] index,
    input  logic [9:0] ball_x,
    input  logic [9:0] ball_y,
    output logic       overlap,
    output logic       centre_in_span
);

    logic [10:0] x0, y0, x1, y1;
    logic [10:0] bx, by, bx_end, by_end, cx;

    // Everything is widened to 11 bits so ball_x + BALL_SIZE never wraps.
    always_comb begin
        x0     = 11'(brick_col(index) * PITCH_X);
        y0     = 11'(brick_row(index) * PITCH_Y);
        x1     = x0 + 11'(BRICK_W);
        y1     = y0 + 11'(BRICK_H);
        bx     = {1'b0, ball_x};
        by     = {1'b0, ball_y};
        bx_end = bx + 11'(BALL_SIZE);
        by_end = by + 11'(BALL_SIZE);
        cx     = bx + 11'(BALL_SIZE / 2);

        overlap        = (bx < x1) && (x0 < bx_end) && (by < y1) && (y0 < by_end);
        centre_in_span = (cx >= x0) && (cx < x1);
    end

endmodule

// File: rtl/brick_manager.sv
// Brick field collision scanner: one brick per cycle, lowest alive overlapped brick wins.
// Define BRICK_MANAGER_MULTIHIT_EN to make row-0 bricks take two hits.
module brick_manager
    import brick_pkg::*;
#(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned SCORE_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               restart,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    output logic [14:0]        alive,
    output logic               hit_valid,
    output logic               bounce_x,
    output logic               bounce_y,
    output logic [SCORE_W-1:0] score,
    output logic               all_clear,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [9:0]         bx_q, bx_d, by_q, by_d;
    logic               found_q, found_d;
    logic [3:0]         hit_idx_q, hit_idx_d;
    logic               centre_q, centre_d;
    logic [14:0]        alive_q, alive_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               hit_valid_q, hit_valid_d;
    logic               bounce_x_q, bounce_x_d;
    logic               bounce_y_q, bounce_y_d;
`ifdef BRICK_MANAGER_MULTIHIT_EN
    logic [NUM_COLS-1:0] cracked_q, cracked_d;
`endif

    logic               overlap, centre_in_span;
    logic [1:0]         hit_row;
    logic [SCORE_W:0]   score_sum;

    brick_overlap #(
        .BALL_SIZE(BALL_SIZE)
    ) u_overlap (
        .index         (idx_q),
        .ball_x        (bx_q),
        .ball_y        (by_q),
        .overlap       (overlap),
        .centre_in_span(centre_in_span)
    );

    assign hit_row   = brick_row(hit_idx_q);
    assign score_sum = {1'b0, score_q} + (SCORE_W + 1)'(brick_points(hit_row));

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        bx_d        = bx_q;
        by_d        = by_q;
        found_d     = found_q;
        hit_idx_d   = hit_idx_q;
        centre_d    = centre_q;
        alive_d     = alive_q;
        score_d     = score_q;
        hit_valid_d = 1'b0;
        bounce_x_d  = 1'b0;
        bounce_y_d  = 1'b0;
`ifdef BRICK_MANAGER_MULTIHIT_EN
        cracked_d   = cracked_q;
`endif

        // restart wins over any scan in flight and over a coincident tick
        if (restart) begin
            state_d = StIdle;
            alive_d = '1;
`ifdef BRICK_MANAGER_MULTIHIT_EN
            cracked_d = '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_tick) begin
                        state_d = StScan;
                        idx_d   = '0;
                        bx_d    = ball_x;
                        by_d    = ball_y;
                        found_d = 1'b0;
                    end
                end
                StScan: begin
                    if (!found_q && alive_q[idx_q] && overlap) begin
                        found_d   = 1'b1;
                        hit_idx_d = idx_q;
                        centre_d  = centre_in_span;
                    end
                    if (idx_q == 4'(NUM_BRICKS - 1)) begin
                        state_d = StResolve;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
                StResolve: begin
                    state_d = StIdle;
                    if (found_q) begin
                        hit_valid_d = 1'b1;
                        bounce_y_d  = centre_q;
                        bounce_x_d  = !centre_q;
`ifdef BRICK_MANAGER_MULTIHIT_EN
                        if (hit_row == 2'd0 && !cracked_q[hit_idx_q[2:0]]) begin
                            cracked_d[hit_idx_q[2:0]] = 1'b1;
                        end else begin
                            alive_d[hit_idx_q] = 1'b0;
                            score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                        end
`else
                        alive_d[hit_idx_q] = 1'b0;
                        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`endif
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            bx_q        <= '0;
            by_q        <= '0;
            found_q     <= 1'b0;
            hit_idx_q   <= '0;
            centre_q    <= 1'b0;
            alive_q     <= '1;
            score_q     <= '0;
            hit_valid_q <= 1'b0;
            bounce_x_q  <= 1'b0;
            bounce_y_q  <= 1'b0;
`ifdef BRICK_MANAGER_MULTIHIT_EN
            cracked_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            found_q     <= found_d;
            hit_idx_q   <= hit_idx_d;
            centre_q    <= centre_d;
            alive_q     <= alive_d;
            score_q     <= score_d;
            hit_valid_q <= hit_valid_d;
            bounce_x_q  <= bounce_x_d;
            bounce_y_q  <= bounce_y_d;
`ifdef BRICK_MANAGER_MULTIHIT_EN
            cracked_q   <= cracked_d;
`endif
        end
    end

    assign alive     = alive_q;
    assign hit_valid = hit_valid_q;
    assign bounce_x  = bounce_x_q;
    assign bounce_y  = bounce_y_q;
    assign score     = score_q;
    assign all_clear = (alive_q == '0);
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_brick_manager.sv
// Directed self-checking bench for brick_manager (honours BRICK_MANAGER_MULTIHIT_EN).
module tb_brick_manager;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        restart;
    logic [9:0]  ball_x;
    logic [9:0]  ball_y;
    logic [14:0] alive;
    logic        hit_valid;
    logic        bounce_x;
    logic        bounce_y;
    logic [7:0]  score;
    logic        all_clear;
    logic        busy;

    int checks = 0;
    int errors = 0;

    brick_manager #(
        .BALL_SIZE(8),
        .SCORE_W  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_tick(frame_tick),
        .restart   (restart),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .alive     (alive),
        .hit_valid (hit_valid),
        .bounce_x  (bounce_x),
        .bounce_y  (bounce_y),
        .score     (score),
        .all_clear (all_clear),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fires one scan and watches 21 sample points; k counts edges after the tick edge.
    task automatic run_scan(input logic [9:0] x, input logic [9:0] y, output int hits,
                            output int hit_cyc, output int busy_cyc,
                            output logic bx, output logic by);
        hits = 0; hit_cyc = -1; busy_cyc = 0; bx = 1'b0; by = 1'b0;
        @(negedge clk);
        ball_x = x; ball_y = y; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (busy === 1'b1) busy_cyc++;
            if (hit_valid === 1'b1) begin
                hits++;
                if (hit_cyc < 0) begin
                    hit_cyc = k; bx = bounce_x; by = bounce_y;
                end
            end
        end
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic clear_level(output int nhits);
        int h, hc, bc;
        logic bx, by;
        int reps;
        nhits = 0;
        for (int i = 0; i < 15; i++) begin
            reps = 1;
`ifdef BRICK_MANAGER_MULTIHIT_EN
            if (i < 5) reps = 2;
`endif
            for (int r = 0; r < reps; r++) begin
                run_scan(10'(128 * (i % 5) + 50), 10'(24 * (i / 5) + 5), h, hc, bc, bx, by);
                nhits += h;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_tick = 1'b0; restart = 1'b0; ball_x = '0; ball_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++; if (alive !== 15'h7FFF) begin errors++; $display("FAIL reset_alive got %h want 7fff", alive); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL reset_score got %0d want 0", score); end
        checks++; if ({hit_valid, bounce_x, bounce_y} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b want 000", {hit_valid, bounce_x, bounce_y}); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL reset_all_clear got %b want 0", all_clear); end
    endtask

    task automatic test_single_hit();
        int h, hc, bc;
        logic bx, by;
`ifdef BRICK_MANAGER_MULTIHIT_EN
        run_scan(10'd4, 10'd4, h, hc, bc, bx, by);
        checks++; if (h !== 1) begin errors++; $display("FAIL crack_hits got %0d want 1", h); end
        checks++; if (alive !== 15'h7FFF) begin errors++; $display("FAIL crack_alive got %h want 7fff", alive); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL crack_score got %0d want 0", score); end
`endif
        run_scan(10'd4, 10'd4, h, hc, bc, bx, by);
        checks++; if (hc !== 16) begin errors++; $display("FAIL single_latency got %0d want 16", hc); end
        checks++; if (h !== 1) begin errors++; $display("FAIL single_hits got %0d want 1", h); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL single_busy got %0d want 16", bc); end
        checks++; if ({bx, by} !== 2'b01) begin errors++; $display("FAIL single_bounce got %b want 01", {bx, by}); end
        checks++; if (alive !== 15'h7FFE) begin errors++; $display("FAIL single_alive got %h want 7ffe", alive); end
        checks++; if (score !== 8'd3) begin errors++; $display("FAIL single_score got %0d want 3", score); end
    endtask

    task automatic test_lowest_index();
        int h, hc, bc;
        logic bx, by;
        // x=122 straddles the 124..127 gap: bricks 5 and 6 both overlap, centre 126 in neither
        run_scan(10'd122, 10'd30, h, hc, bc, bx, by);
        checks++; if (h !== 1) begin errors++; $display("FAIL lowest_hits got %0d want 1", h); end
        checks++; if ({bx, by} !== 2'b10) begin errors++; $display("FAIL lowest_bounce got %b want 10", {bx, by}); end
        checks++; if (alive !== 15'h7FDE) begin errors++; $display("FAIL lowest_alive got %h want 7fde", alive); end
        checks++; if (score !== 8'd5) begin errors++; $display("FAIL lowest_score got %0d want 5", score); end
        run_scan(10'd126, 10'd30, h, hc, bc, bx, by);
        checks++; if ({bx, by} !== 2'b01) begin errors++; $display("FAIL edge_bounce got %b want 01", {bx, by}); end
        checks++; if (alive !== 15'h7F9E) begin errors++; $display("FAIL edge_alive got %h want 7f9e", alive); end
        checks++; if (score !== 8'd7) begin errors++; $display("FAIL edge_score got %0d want 7", score); end
    endtask

    task automatic test_miss();
        int h, hc, bc;
        logic bx, by;
        // brick 0 is dead and brick 1 starts exactly at the ball's exclusive right edge
        run_scan(10'd120, 10'd0, h, hc, bc, bx, by);
        checks++; if (h !== 0) begin errors++; $display("FAIL boundary_hits got %0d want 0", h); end
        run_scan(10'd300, 10'd200, h, hc, bc, bx, by);
        checks++; if (h !== 0) begin errors++; $display("FAIL miss_hits got %0d want 0", h); end
        checks++; if (bc !== 16) begin errors++; $display("FAIL miss_busy got %0d want 16", bc); end
        checks++; if (alive !== 15'h7F9E) begin errors++; $display("FAIL miss_alive got %h want 7f9e", alive); end
        checks++; if (score !== 8'd7) begin errors++; $display("FAIL miss_score got %0d want 7", score); end
    endtask

    task automatic test_back_to_back();
        int hits = 0;
        int hc = -1;
        @(negedge clk);
        ball_x = 10'd300; ball_y = 10'd50; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 4) frame_tick = 1'b1;
            if (k == 5) frame_tick = 1'b0;
            if (hit_valid === 1'b1) begin
                hits++;
                if (hc < 0) hc = k;
            end
        end
        checks++; if (hits !== 1) begin errors++; $display("FAIL b2b_hits got %0d want 1", hits); end
        checks++; if (hc !== 16) begin errors++; $display("FAIL b2b_latency got %0d want 16", hc); end
        checks++; if (alive !== 15'h6F9E) begin errors++; $display("FAIL b2b_alive got %h want 6f9e", alive); end
        checks++; if (score !== 8'd8) begin errors++; $display("FAIL b2b_score got %0d want 8", score); end
    endtask

    task automatic test_restart_abort();
        int hits = 0;
        @(negedge clk);
        ball_x = 10'd300; ball_y = 10'd30; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 1; k <= 7; k++) @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (alive !== 15'h7FFF) begin errors++; $display("FAIL abort_alive got %h want 7fff", alive); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hit_valid === 1'b1) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL abort_hits got %0d want 0", hits); end
        checks++; if (score !== 8'd8) begin errors++; $display("FAIL abort_score got %0d want 8", score); end
        // coincident restart and tick: the tick is dropped
        hits = 0;
        @(negedge clk);
        ball_x = 10'd4; ball_y = 10'd4; frame_tick = 1'b1; restart = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0; restart = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL coincide_busy got %b want 0", busy); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hit_valid === 1'b1) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL coincide_hits got %0d want 0", hits); end
        checks++; if (alive !== 15'h7FFF) begin errors++; $display("FAIL coincide_alive got %h want 7fff", alive); end
    endtask

    task automatic test_reset_mid_scan();
        int hits = 0;
        @(negedge clk);
        ball_x = 10'd300; ball_y = 10'd30; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        for (int k = 1; k <= 7; k++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rstmid_score got %0d want 0", score); end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (hit_valid === 1'b1) hits++;
        end
        checks++; if (hits !== 0) begin errors++; $display("FAIL rstmid_hits got %0d want 0", hits); end
        checks++; if (alive !== 15'h7FFF) begin errors++; $display("FAIL rstmid_alive got %h want 7fff", alive); end
    endtask

    task automatic test_clear_all();
        int nhits;
        int want_hits = 15;
`ifdef BRICK_MANAGER_MULTIHIT_EN
        want_hits = 20;
`endif
        clear_level(nhits);
        checks++; if (nhits !== want_hits) begin errors++; $display("FAIL clear_hits got %0d want %0d", nhits, want_hits); end
        checks++; if (alive !== 15'h0000) begin errors++; $display("FAIL clear_alive got %h want 0000", alive); end
        checks++; if (all_clear !== 1'b1) begin errors++; $display("FAIL clear_flag got %b want 1", all_clear); end
        checks++; if (score !== 8'd30) begin errors++; $display("FAIL clear_score got %0d want 30", score); end
        pulse_restart();
        checks++; if (alive !== 15'h7FFF) begin errors++; $display("FAIL restore_alive got %h want 7fff", alive); end
        checks++; if (score !== 8'd30) begin errors++; $display("FAIL restore_score got %0d want 30", score); end
        checks++; if (all_clear !== 1'b0) begin errors++; $display("FAIL restore_flag got %b want 0", all_clear); end
        // eight more levels push the raw total to 270, past the 8-bit ceiling
        for (int lv = 0; lv < 8; lv++) begin
            clear_level(nhits);
            checks++; if (nhits !== want_hits) begin errors++; $display("FAIL level%0d_hits got %0d want %0d", lv, nhits, want_hits); end
            pulse_restart();
        end
        checks++; if (score !== 8'd255) begin errors++; $display("FAIL saturate_score got %0d want 255", score); end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_lowest_index();
        test_miss();
        test_back_to_back();
        test_restart_abort();
        test_reset_mid_scan();
        test_clear_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
